// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback-side bus between the NUM_REQ writeback sources, the
// arbiter and the register_controller write port.
//   req_valid/req_ready   per-requester handshake (bit i belongs to requester i)
//   req_addr/req_data     packed per requester; slice i = [i*W +: W]
//   stall                 suppresses all grants in the current cycle
//   rf_write_*            registered write command towards register_controller
//   grant_id              requester behind the current rf_write_* command
//   fwd_*                 optional read bypass, present only with REGFILE_ARB_FWD_EN
// Modports: master = writeback/requester side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int REG_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_REQ     = 3,
    parameter int GRANT_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*REG_WIDTH-1:0]  req_data;
    logic                          stall;
    logic                          rf_write_enable;
    logic [ADDR_WIDTH-1:0]         rf_write_addr;
    logic [REG_WIDTH-1:0]          rf_write_data;
    logic [GRANT_WIDTH-1:0]        grant_id;
`ifdef REGFILE_ARB_FWD_EN
    logic [ADDR_WIDTH-1:0]         fwd_addr_0;
    logic [ADDR_WIDTH-1:0]         fwd_addr_1;
    logic                          fwd_hit_0;
    logic                          fwd_hit_1;
    logic [REG_WIDTH-1:0]          fwd_data_0;
    logic [REG_WIDTH-1:0]          fwd_data_1;
`endif

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, rf_write_enable, rf_write_addr, rf_write_data, grant_id
`ifdef REGFILE_ARB_FWD_EN
        , output fwd_addr_0, fwd_addr_1,
        input  fwd_hit_0, fwd_hit_1, fwd_data_0, fwd_data_1
`endif
    );

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, rf_write_enable, rf_write_addr, rf_write_data, grant_id
`ifdef REGFILE_ARB_FWD_EN
        , input fwd_addr_0, fwd_addr_1,
        output fwd_hit_0, fwd_hit_1, fwd_data_0, fwd_data_1
`endif
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the single register-file write port
// among NUM_REQ writeback sources, one write issued per cycle.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_write_arbiter_if.slave: req_valid/req_ready/req_addr/req_data/stall in,
//          rf_write_enable/rf_write_addr/rf_write_data/grant_id out (one cycle after grant)
// Optional feature macro REGFILE_ARB_FWD_EN: adds combinational forwarding of the in-flight
// write to two read ports (bus.fwd_addr_k -> bus.fwd_hit_k/bus.fwd_data_k).
module regfile_write_arbiter #(
    parameter int REG_WIDTH       = 32,
    parameter int NUM_REGS        = 32,
    parameter int ADDR_WIDTH      = $clog2(NUM_REGS),
    parameter bit REG_ZERO_GROUND = 1'b1,
    parameter int NUM_REQ         = 3
) (
    input logic clk,
    input logic rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         winner;
    logic [GW-1:0]         gid_q;
    logic                  found;
    logic                  grant;
    logic                  issue;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0]  win_data;
    logic [REG_WIDTH-1:0]  data_q;
    int                    idx;

    // Scan from rr_ptr upwards (mod NUM_REQ); the first valid requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                winner = GW'(idx);
                found  = 1'b1;
            end
        end
    end

    // Ready is gated by rst_n so no handshake completes while the arbiter is held in reset.
    assign grant    = found && !bus.stall && rst_n;
    assign win_addr = bus.req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data = bus.req_data[winner*REG_WIDTH +: REG_WIDTH];
    // A grounded register 0 write is accepted from the requester but never reaches the file.
    assign issue    = !(REG_ZERO_GROUND && win_addr == '0);

    assign bus.req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
        end else begin
            we_q <= grant && issue;
            if (grant)
                rr_ptr <= (winner == GW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            // Address/data/id only move on an issued write; otherwise they hold.
            if (grant && issue) begin
                addr_q <= win_addr;
                data_q <= win_data;
                gid_q  <= winner;
            end
        end
    end

    assign bus.rf_write_enable = we_q;
    assign bus.rf_write_addr   = addr_q;
    assign bus.rf_write_data   = data_q;
    assign bus.grant_id        = gid_q;

`ifdef REGFILE_ARB_FWD_EN
    // A grounded register 0 is never enabled, so it can never produce a hit.
    logic hit_0;
    logic hit_1;
    assign hit_0          = we_q && (addr_q == bus.fwd_addr_0);
    assign hit_1          = we_q && (addr_q == bus.fwd_addr_1);
    assign bus.fwd_hit_0  = hit_0;
    assign bus.fwd_hit_1  = hit_1;
    assign bus.fwd_data_0 = hit_0 ? data_q : '0;
    assign bus.fwd_data_1 = hit_1 ? data_q : '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed table-driven bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h3333_0002;
    localparam logic [14:0] A_STD = {5'd5, 5'd4, 5'd3};
    localparam logic [14:0] A_Z   = {5'd5, 5'd0, 5'd3};
    localparam logic [14:0] A_31  = {5'd31, 5'd4, 5'd3};
    localparam logic [95:0] DSTD  = {D2, D1, D0};
    localparam logic [95:0] DZ    = {D2, 32'h1234_5678, D0};

    typedef struct {
        logic [2:0]  valid;
        logic        stall;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  er;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [1:0]  eg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t tv [16];
    logic [31:0] rf [32] = '{default: '0};

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.REG_WIDTH(32), .ADDR_WIDTH(5), .NUM_REQ(3)) bus ();

    regfile_write_arbiter #(
        .REG_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .REG_ZERO_GROUND(1'b1), .NUM_REQ(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Behavioural register file standing in for register_controller.
    always @(posedge clk)
        if (bus.rf_write_enable) rf[bus.rf_write_addr] <= bus.rf_write_data;

    function automatic vec_t mk(logic [2:0] valid, logic stall, logic [14:0] addr, logic [95:0] data,
                                logic [2:0] er, logic ewe, logic [4:0] ea, logic [31:0] ed, logic [1:0] eg);
        vec_t v;
        v.valid = valid; v.stall = stall; v.addr = addr; v.data = data;
        v.er = er; v.ewe = ewe; v.ea = ea; v.ed = ed; v.eg = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] valid, input logic stall, input logic [14:0] addr, input logic [95:0] data);
        bus.req_valid = valid;
        bus.stall     = stall;
        bus.req_addr  = addr;
        bus.req_data  = data;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d, input logic [1:0] g);
        chk({tag, " we"},   32'(bus.rf_write_enable), 32'(we));
        chk({tag, " addr"}, 32'(bus.rf_write_addr),   32'(a));
        chk({tag, " data"}, bus.rf_write_data,        d);
        chk({tag, " gid"},  32'(bus.grant_id),        32'(g));
    endtask

    initial begin
        // Outputs shown are those visible during the vector's cycle (rf_* reflect the previous grant).
        tv[0]  = mk(3'b111, 0, A_STD, DSTD, 3'b001, 0, 5'd0,  32'h0, 2'd0);
        tv[1]  = mk(3'b111, 0, A_STD, DSTD, 3'b010, 1, 5'd3,  D0,    2'd0);
        tv[2]  = mk(3'b111, 0, A_STD, DSTD, 3'b100, 1, 5'd4,  D1,    2'd1);
        tv[3]  = mk(3'b111, 0, A_STD, DSTD, 3'b001, 1, 5'd5,  D2,    2'd2);
        tv[4]  = mk(3'b111, 1, A_STD, DSTD, 3'b000, 1, 5'd3,  D0,    2'd0);
        tv[5]  = mk(3'b111, 1, A_STD, DSTD, 3'b000, 0, 5'd3,  D0,    2'd0);
        tv[6]  = mk(3'b111, 1, A_STD, DSTD, 3'b000, 0, 5'd3,  D0,    2'd0);
        tv[7]  = mk(3'b111, 0, A_STD, DSTD, 3'b010, 0, 5'd3,  D0,    2'd0);
        tv[8]  = mk(3'b010, 0, A_Z,   DZ,   3'b010, 1, 5'd4,  D1,    2'd1);
        tv[9]  = mk(3'b000, 0, A_STD, DSTD, 3'b000, 0, 5'd4,  D1,    2'd1);
        tv[10] = mk(3'b100, 0, A_31,  DSTD, 3'b100, 0, 5'd4,  D1,    2'd1);
        tv[11] = mk(3'b011, 0, A_STD, DSTD, 3'b001, 1, 5'd31, D2,    2'd2);
        tv[12] = mk(3'b000, 0, A_STD, DSTD, 3'b000, 1, 5'd3,  D0,    2'd0);
        tv[13] = mk(3'b110, 0, A_STD, DSTD, 3'b010, 0, 5'd3,  D0,    2'd0);
        tv[14] = mk(3'b101, 0, A_STD, DSTD, 3'b100, 1, 5'd4,  D1,    2'd1);
        tv[15] = mk(3'b000, 0, A_STD, DSTD, 3'b000, 1, 5'd5,  D2,    2'd2);

`ifdef REGFILE_ARB_FWD_EN
        bus.fwd_addr_0 = 5'd0;
        bus.fwd_addr_1 = 5'd0;
`endif
        // Reset: requests present but nothing may be accepted.
        drive(3'b111, 0, A_STD, DSTD);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(bus.req_ready), 32'h0);
        chk_out("reset", 0, 5'd0, 32'h0, 2'd0);
        drive(3'b000, 0, A_STD, DSTD);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 drive(tv[i].valid, tv[i].stall, tv[i].addr, tv[i].data);
            @(negedge clk);
            chk($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'(tv[i].er));
            chk_out($sformatf("v%0d", i), tv[i].ewe, tv[i].ea, tv[i].ed, tv[i].eg);
        end
        chk("reg0 grounded", rf[0], 32'h0);
        chk("reg31 written", rf[31], D2);

        // Single request, one-cycle latency, then readable from the file.
        @(posedge clk);
        #1 drive(3'b001, 0, {5'd5, 5'd4, 5'd1}, {D2, D1, 32'hDEAD_BEEF});
`ifdef REGFILE_ARB_FWD_EN
        bus.fwd_addr_0 = 5'd1;
        bus.fwd_addr_1 = 5'd2;
`endif
        @(negedge clk);
        chk("single ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1 drive(3'b000, 0, A_STD, DSTD);
        @(negedge clk);
        chk_out("single", 1, 5'd1, 32'hDEAD_BEEF, 2'd0);
`ifdef REGFILE_ARB_FWD_EN
        chk("fwd hit0",  32'(bus.fwd_hit_0), 32'h1);
        chk("fwd data0", bus.fwd_data_0,     32'hDEAD_BEEF);
        chk("fwd hit1",  32'(bus.fwd_hit_1), 32'h0);
        chk("fwd data1", bus.fwd_data_1,     32'h0);
`endif
        @(negedge clk);
        chk("reg1 read", rf[1], 32'hDEAD_BEEF);

        // Reset right after a grant: the in-flight write is dropped and rr_ptr returns to 0.
        @(posedge clk);
        #1 drive(3'b010, 0, {5'd5, 5'd31, 5'd3}, {D2, 32'hAABB_CCDD, D0});
        @(negedge clk);
        chk("rst grant ready", 32'(bus.req_ready), 32'h2);
        @(posedge clk);
        #1 begin
            rst_n = 1'b0;
            drive(3'b000, 0, A_STD, DSTD);
        end
        @(negedge clk);
        chk("rst mid ready", 32'(bus.req_ready), 32'h0);
        chk_out("rst mid", 0, 5'd0, 32'h0, 2'd0);
        @(posedge clk);
        #1 chk("rst write lost", rf[31], D2);
        drive(3'b111, 0, A_STD, DSTD);
        rst_n = 1'b1;
        #1 chk("rst rr_ptr", 32'(bus.req_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
